// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo - FIFO-buffered UART transmitter (8N1 default) with BREAK;
//   define UART_TX_FIFO_PARITY_EN to add an even-parity bit.   Rev 1.0
// ============================================================================
module uart_tx_fifo #(
  parameter int CLK_HZ       = 50000000,
  parameter int BIT_RATE     = 4800,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [PAYLOAD_BITS-1:0]       wr_data,
  input  logic                          break_req,
  output logic                          uart_txd,
  output logic                          uart_tx_busy,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_overflow
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int TW = $clog2(CYCLES_PER_BIT);
  localparam int BW = $clog2(PAYLOAD_BITS + 1);
  localparam int KW = $clog2(PAYLOAD_BITS + 3);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [TW-1:0] TIMER_LAST = TW'(CYCLES_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(PAYLOAD_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);
  localparam logic [KW-1:0] BRK_LAST   = KW'(PAYLOAD_BITS + 1);
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(FIFO_DEPTH);

`ifdef UART_TX_FIFO_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4, S_BREAK = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd4, S_BREAK = 3'd5
  } state_t;
`endif

  state_t                  state_q;
  logic [TW-1:0]           timer_q;
  logic [BW-1:0]           bit_q;
  logic [KW-1:0]           brk_q;
  logic                    brk_min_q;
  logic [PAYLOAD_BITS-1:0] shift_q;
  logic                    txd_q;
`ifdef UART_TX_FIFO_PARITY_EN
  logic                    parity_q;
`endif

  logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q;
  logic [AW-1:0]           rd_ptr_q;
  logic [AW:0]             count_q;
  logic                    ovf_q;

  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    bit_end;
  logic                    stop_end;
  logic                    brk_done;
  logic [PAYLOAD_BITS-1:0] head;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign push     = wr_en && !full;
  assign bit_end  = (timer_q == TIMER_LAST);
  assign stop_end = (state_q == S_STOP) && bit_end && (bit_q == STOP_LAST);
  // Pop decisions must mirror the IDLE / last-STOP branches of the FSM below.
  assign pop      = ((state_q == S_IDLE) || stop_end) && !break_req && !empty;
  assign brk_done = brk_min_q || (bit_end && (brk_q == BRK_LAST));
  assign head     = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_en && full) ovf_q <= 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_q     <= '0;
      brk_q     <= '0;
      brk_min_q <= 1'b0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
`ifdef UART_TX_FIFO_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      timer_q <= bit_end ? '0 : timer_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          timer_q <= '0;
          bit_q   <= '0;
          if (break_req) begin
            state_q   <= S_BREAK;
            txd_q     <= 1'b0;
            brk_q     <= '0;
            brk_min_q <= 1'b0;
          end else if (!empty) begin
            state_q  <= S_START;
            txd_q    <= 1'b0;
            shift_q  <= head;
`ifdef UART_TX_FIFO_PARITY_EN
            parity_q <= ^head;
`endif
          end else begin
            txd_q <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_q == DATA_LAST) begin
`ifdef UART_TX_FIFO_PARITY_EN
              state_q <= S_PARITY;
              txd_q   <= parity_q;
`else
              state_q <= S_STOP;
              txd_q   <= 1'b1;
              bit_q   <= '0;
`endif
            end else begin
              bit_q   <= bit_q + 1'b1;
              txd_q   <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
`ifdef UART_TX_FIFO_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state_q <= S_STOP;
            txd_q   <= 1'b1;
            bit_q   <= '0;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            if (bit_q == STOP_LAST) begin
              // Chain straight into the next frame or break with no idle gap.
              bit_q <= '0;
              if (break_req) begin
                state_q   <= S_BREAK;
                txd_q     <= 1'b0;
                brk_q     <= '0;
                brk_min_q <= 1'b0;
              end else if (!empty) begin
                state_q  <= S_START;
                txd_q    <= 1'b0;
                shift_q  <= head;
`ifdef UART_TX_FIFO_PARITY_EN
                parity_q <= ^head;
`endif
              end else begin
                state_q <= S_IDLE;
                txd_q   <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        S_BREAK: begin
          // Minimum break length is fixed; afterwards it lasts while break_req holds.
          if (brk_done && !break_req) begin
            state_q <= S_STOP;
            txd_q   <= 1'b1;
            timer_q <= '0;
            bit_q   <= '0;
          end else if (bit_end && !brk_min_q) begin
            if (brk_q == BRK_LAST) begin
              brk_min_q <= 1'b1;
            end else begin
              brk_q <= brk_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign uart_txd     = txd_q;
  assign uart_tx_busy = (state_q != S_IDLE);
  assign fifo_full    = full;
  assign fifo_empty   = empty;
  assign fifo_count   = count_q;
  assign tx_overflow  = ovf_q;

endmodule
`default_nettype wire
